// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine dispense controller:
// state encoding, output bundle, credit width and coin unit.
package vend_pkg;

    localparam int CS_W                = 4;
    localparam int COIN_UNIT_CENTS     = 5;
    localparam int DEFAULT_PRICE_UNITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VEND     = 3'd1,
        ST_CHG_ON   = 3'd2,
        ST_CHG_GAP  = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_CLR = 3'd5
    } state_t;

    typedef struct packed {
        logic product;
        logic change_pulse;
        logic busy;
        logic vend_done;
    } outs_t;

    // Moore output decode; unused encodings drive everything low.
    function automatic outs_t decode_outputs(input state_t st);
        outs_t o;
        o = '0;
        case (st)
            ST_IDLE:     o = '0;
            ST_VEND:     begin o.product = 1'b1; o.busy = 1'b1; end
            ST_CHG_ON:   begin o.change_pulse = 1'b1; o.busy = 1'b1; end
            ST_CHG_GAP:  o.busy = 1'b1;
            ST_DONE:     begin o.vend_done = 1'b1; o.busy = 1'b1; end
            ST_WAIT_CLR: o.busy = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/vend_down_timer.sv
// 4-bit loadable down counter with a registered zero flag. Load wins over
// enable; the counter stops at zero rather than wrapping.
module vend_down_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] count,
    output logic       zero
);

    logic [3:0] count_r;
    logic       zero_r;

    // Counter register with zero flag kept in step with the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
            zero_r  <= 1'b1;
        end else if (load) begin
            count_r <= load_val;
            zero_r  <= (load_val == 4'd0);
        end else if (en && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
            zero_r  <= (count_r == 4'd1);
        end else begin
            count_r <= count_r;
            zero_r  <= zero_r;
        end
    end

    assign count = count_r;
    assign zero  = zero_r;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer downstream of the vending state memory: on sufficient
// credit it drives the product motor, returns change one coin pulse at a
// time, then signals vend_done and waits for the credit to be cleared.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS = DEFAULT_PRICE_UNITS,
    parameter int PULSE_W     = 4,
    parameter int GAP_W       = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CS_W-1:0] CS,
    output logic            product,
    output logic            change_pulse,
    output logic            busy,
    output logic            vend_done
);

    localparam logic [3:0] PRICE_L = 4'(PRICE_UNITS);
    localparam logic [3:0] PULSE_L = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_L   = 4'(GAP_W - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] change_r;
    outs_t      outs_r;

    logic       timer_load_s;
    logic [3:0] timer_val_s;
    logic       timer_en_s;
    logic [3:0] timer_count_s;
    logic       timer_zero_s;

    vend_down_timer u_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .en       (timer_en_s),
        .count    (timer_count_s),
        .zero     (timer_zero_s)
    );

    // Next-state selection and timer control from the current state.
    always_comb begin
        next_state_s = state_r;
        timer_load_s = 1'b0;
        timer_val_s  = 4'd0;
        timer_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (CS >= PRICE_L) begin
                    next_state_s = ST_VEND;
                    timer_load_s = 1'b1;
                    timer_val_s  = PULSE_L;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_VEND, ST_CHG_GAP: begin
                if (timer_zero_s) begin
                    if (change_r != 4'd0) begin
                        next_state_s = ST_CHG_ON;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = state_r;
                    timer_en_s   = 1'b1;
                end
            end
            ST_CHG_ON: begin
                next_state_s = ST_CHG_GAP;
                timer_load_s = 1'b1;
                timer_val_s  = GAP_L;
            end
            ST_DONE: begin
                next_state_s = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (CS < PRICE_L) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_CLR;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, captured change and registered output decode.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= ST_IDLE;
            change_r <= 4'd0;
            outs_r   <= '0;
        end else begin
            state_r <= next_state_s;
            outs_r  <= decode_outputs(next_state_s);
            case (state_r)
                ST_IDLE: begin
                    if (CS >= PRICE_L) begin
                        change_r <= CS - PRICE_L;
                    end else begin
                        change_r <= change_r;
                    end
                end
                ST_CHG_ON: begin
                    change_r <= change_r - 4'd1;
                end
                default: begin
                    change_r <= change_r;
                end
            endcase
        end
    end

    assign product      = outs_r.product;
    assign change_pulse = outs_r.change_pulse;
    assign busy         = outs_r.busy;
    assign vend_done    = outs_r.vend_done;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl. The expected output trace of
// each vend is built from the pricing rules as a list of per-cycle output
// vectors {product, change_pulse, busy, vend_done}.
module tb_vend_dispense_ctrl;

    localparam int PRICE = 5;
    localparam int PW    = 4;
    localparam int GW    = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] CS  = 4'd0;
    logic       product;
    logic       change_pulse;
    logic       busy;
    logic       vend_done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    vend_dispense_ctrl #(
        .PRICE_UNITS (PRICE),
        .PULSE_W     (PW),
        .GAP_W       (GW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CS           (CS),
        .product      (product),
        .change_pulse (change_pulse),
        .busy         (busy),
        .vend_done    (vend_done)
    );

    function automatic logic [3:0] outs();
        return {product, change_pulse, busy, vend_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] low_credit();
        return 4'($urandom_range(PRICE - 1, 0));
    endfunction

    // One full vend: trigger with cs_val, change CS to mid_cs during the
    // sequence, then keep stale credit for hold cycles before clearing it.
    task automatic vend(input logic [3:0] cs_val, input logic [3:0] mid_cs, input int hold);
        logic [3:0] exp_q[$];
        int         chg;
        int         pulses;
        logic [3:0] stale;
        chg    = int'(cs_val) - PRICE;
        pulses = 0;
        for (int i = 0; i < PW; i++) exp_q.push_back(4'b1010);
        for (int k = 0; k < chg; k++) begin
            exp_q.push_back(4'b0110);
            for (int g = 0; g < GW; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0011);

        CS = cs_val;
        step();
        CS = mid_cs;
        for (int i = 0; i < exp_q.size(); i++) begin
            check("vend_seq", 32'(outs()), 32'(exp_q[i]));
            if (change_pulse) pulses++;
            if (i != exp_q.size() - 1) step();
        end
        check("chg_count", 32'(pulses), 32'(chg));

        stale = 4'($urandom_range(15, PRICE));
        CS = (hold > 0) ? stale : low_credit();
        step();
        check("wait_clr", 32'(outs()), 32'(4'b0010));
        for (int h = 1; h < hold; h++) begin
            step();
            check("stale_hold", 32'(outs()), 32'(4'b0010));
        end
        CS = low_credit();
        step();
        check("back_idle", 32'(outs()), 32'(4'b0000));
    endtask

    initial begin
        // Power-on reset
        RST = 1'b0;
        CS  = 4'd0;
        step();
        step();
        check("reset_state", 32'(outs()), 32'(4'b0000));
        RST = 1'b1;
        step();
        check("idle_after_reset", 32'(outs()), 32'(4'b0000));

        // Asynchronous reset in the middle of VEND
        CS = 4'd7;
        step();
        check("rst_pre_vend", 32'(outs()), 32'(4'b1010));
        step();
        RST = 1'b0;
        #1;
        check("rst_async", 32'(outs()), 32'(4'b0000));
        CS = 4'd0;
        step();
        check("rst_held", 32'(outs()), 32'(4'b0000));
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rst_no_done", 32'(outs()), 32'(4'b0000));
        end

        // Exact price, change, max credit
        vend(4'd5, 4'd0, 0);
        vend(4'd8, 4'd2, 0);
        vend(4'd15, 4'd15, 0);

        // Stale credit held after vend_done, then a fresh vend
        vend(4'd6, 4'd6, 6);
        vend(4'd6, 4'd0, 0);

        // Credit raised mid-vend is ignored
        vend(4'd5, 4'd9, 1);

        // Idle with insufficient credit
        for (int i = 0; i < 6; i++) begin
            CS = low_credit();
            step();
            check("idle_low_cs", 32'(outs()), 32'(4'b0000));
        end

        // Randomised vends
        for (int n = 0; n < 16; n++) begin
            vend(4'($urandom_range(15, PRICE)), 4'($urandom_range(15, 0)),
                 int'($urandom_range(4, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
